// File: rtl/sram_access_ctrl.sv
// Single-word access sequencer for the external async SRAM (LC-3 MAR/MDR path).
// Request/done handshake; all strobes decode from state plus latched request fields.
module sram_access_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Write,
    input  logic [1:0]  ByteEn,
    input  logic [15:0] Addr,
    input  logic [15:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] RData,
    output logic        CE,
    output logic        OE,
    output logic        WE,
    output logic        UB,
    output logic        LB,
    output logic [19:0] ADDR,
    output logic [15:0] Data_out,
    output logic        Data_oe,
    input  logic [15:0] Data_in
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        accept;
    logic        active;
    logic        strobe;

    logic        write_q;
    logic [1:0]  be_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            write_q <= 1'b0;
            be_q    <= 2'b00;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            RData   <= 16'h0000;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                write_q <= Write;
                be_q    <= ByteEn;
                addr_q  <= Addr;
                wdata_q <= WData;
            end
            // Capture on the edge that closes the last strobe cycle; disabled lanes read as zero.
            if (state == ACCESS && cnt == 4'd0 && !write_q) begin
                RData <= {be_q[1] ? Data_in[15:8] : 8'h00,
                          be_q[0] ? Data_in[7:0]  : 8'h00};
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = Req && (state == IDLE || state == FINISH);
        case (state)
            IDLE: begin
                if (accept) state_next = SETUP;
            end
            SETUP: begin
                state_next = ACCESS;
                cnt_next   = WAIT_LOAD;
            end
            ACCESS: begin
                if (cnt == 4'd0) state_next = FINISH;
                else             cnt_next   = cnt - 4'd1;
            end
            FINISH: begin
                state_next = accept ? SETUP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // CE and the data drive span SETUP..FINISH so write data is held after WE rises.
    always_comb begin
        active  = (state != IDLE);
        strobe  = (state == ACCESS);
        CE      = ~active;
        OE      = ~(strobe && !write_q);
        WE      = ~(strobe && write_q);
        UB      = ~(active && be_q[1]);
        LB      = ~(active && be_q[0]);
        Data_oe = active && write_q;
        Busy    = (state == SETUP) || (state == ACCESS);
        Done    = (state == FINISH);
    end

    assign ADDR     = {4'h0, addr_q};
    assign Data_out = wdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: per-cycle strobe/handshake expectations derived from the
// cycle index since acceptance, plus a read-data model; WAIT_CYCLES=2 and 1 instances.
module tb_sram_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req, Write;
    logic [1:0]  ByteEn;
    logic [15:0] Addr, WData, Data_in;
    logic        Busy, Done, CE, OE, WE, UB, LB, Data_oe;
    logic [15:0] RData, Data_out;
    logic [19:0] ADDR;

    logic        s_req, s_write;
    logic [1:0]  s_byte_en;
    logic [15:0] s_addr, s_wdata, s_data_in;
    logic        s_busy, s_done, s_ce, s_oe, s_we, s_ub, s_lb, s_data_oe;
    logic [15:0] s_rdata, s_data_out;
    logic [19:0] s_sram_addr;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] rd_exp   = 16'h0000;
    logic [15:0] s_rd_exp = 16'h0000;
    logic        mon_en   = 1'b0;

    always #5 Clk = ~Clk;

    sram_access_ctrl #(.WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Write(Write), .ByteEn(ByteEn),
        .Addr(Addr), .WData(WData), .Busy(Busy), .Done(Done), .RData(RData),
        .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .ADDR(ADDR),
        .Data_out(Data_out), .Data_oe(Data_oe), .Data_in(Data_in)
    );

    sram_access_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Req(s_req), .Write(s_write), .ByteEn(s_byte_en),
        .Addr(s_addr), .WData(s_wdata), .Busy(s_busy), .Done(s_done), .RData(s_rdata),
        .CE(s_ce), .OE(s_oe), .WE(s_we), .UB(s_ub), .LB(s_lb), .ADDR(s_sram_addr),
        .Data_out(s_data_out), .Data_oe(s_data_oe), .Data_in(s_data_in)
    );

    // Expected {CE,OE,WE,UB,LB,Data_oe,Busy,Done} in cycle k after acceptance (k<1 or past Done = idle).
    function automatic logic [7:0] exp_sig(input int k, input int wc, input logic wr,
                                           input logic [1:0] be);
        logic act, stb, bsy, dn;
        act = (k >= 1) && (k <= wc + 2);
        stb = (k >= 2) && (k <= wc + 1);
        bsy = (k >= 1) && (k <= wc + 1);
        dn  = (k == wc + 2);
        return {~act, ~(stb & ~wr), ~(stb & wr), ~(act & be[1]), ~(act & be[0]),
                act & wr, bsy, dn};
    endfunction

    function automatic logic [15:0] masked(input logic [15:0] din, input logic [1:0] be);
        return {be[1] ? din[15:8] : 8'h00, be[0] ? din[7:0] : 8'h00};
    endfunction

    always @(negedge Clk) begin
        if (mon_en) begin
            checks++;
            if ((OE === 1'b0 && WE === 1'b0) || (Data_oe === 1'b1 && OE === 1'b0)) begin
                failures++;
                $display("FAIL strobe_excl OE=%b WE=%b Data_oe=%b (never OE&WE low, never Data_oe with OE low)",
                         OE, WE, Data_oe);
            end
            checks++;
            if ((s_oe === 1'b0 && s_we === 1'b0) || (s_data_oe === 1'b1 && s_oe === 1'b0)) begin
                failures++;
                $display("FAIL strobe_excl_wc1 OE=%b WE=%b Data_oe=%b", s_oe, s_we, s_data_oe);
            end
        end
    end

    // Drives a request, returns just after the accepting edge; scrambles request fields unless held.
    task automatic start_req(input logic wr, input logic [1:0] be, input logic [15:0] a,
                             input logic [15:0] wd, input logic [15:0] din, input logic hold);
        @(posedge Clk);
        #1;
        Req = 1'b1; Write = wr; ByteEn = be; Addr = a; WData = wd; Data_in = din;
        @(posedge Clk);
        #1;
        if (!hold) begin
            Req = 1'b0;
            Write = ~wr; ByteEn = ~be; Addr = 16'($urandom); WData = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Req = 1'b0; Write = 1'b0; ByteEn = 2'b00; Addr = 16'h0; WData = 16'h0; Data_in = 16'h0;
        s_req = 1'b0; s_write = 1'b0; s_byte_en = 2'b00; s_addr = 16'h0; s_wdata = 16'h0;
        s_data_in = 16'h0;
        #1 Reset = 1'b1;
        #2;
        checks++;
        if ({CE, OE, WE, UB, LB, Data_oe, Busy, Done} !== 8'b11111000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=11111000",
                     {CE, OE, WE, UB, LB, Data_oe, Busy, Done});
        end
        checks++;
        if (ADDR !== 20'h0 || Data_out !== 16'h0 || RData !== 16'h0) begin
            failures++;
            $display("FAIL reset_data ADDR=%h Data_out=%h RData=%h exp all zero", ADDR, Data_out, RData);
        end
        checks++;
        if ({s_ce, s_oe, s_we, s_ub, s_lb, s_data_oe, s_busy, s_done} !== 8'b11111000 ||
            s_rdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_wc1 strobes=%b RData=%h", {s_ce, s_oe, s_we, s_ub, s_lb,
                     s_data_oe, s_busy, s_done}, s_rdata);
        end
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_access();
        logic        wr;
        logic [1:0]  be;
        logic [15:0] a, wd, din;
        logic [7:0]  obs, e;
        for (int n = 0; n < 44; n++) begin
            case (n)
                0: begin wr = 1'b0; be = 2'b11; a = 16'h3000; wd = 16'h0;    din = 16'hBEEF; end
                1: begin wr = 1'b1; be = 2'b11; a = 16'h0012; wd = 16'h1234; din = 16'h5555; end
                2: begin wr = 1'b0; be = 2'b10; a = 16'h0100; wd = 16'h0;    din = 16'hA55A; end
                3: begin wr = 1'b0; be = 2'b00; a = 16'h0101; wd = 16'h0;    din = 16'hA55A; end
                default: begin
                    wr = 1'($urandom_range(0, 1)); be = 2'($urandom_range(0, 3));
                    a = 16'($urandom); wd = 16'($urandom); din = 16'($urandom);
                end
            endcase
            start_req(wr, be, a, wd, din, 1'b0);
            for (int k = 1; k <= 5; k++) begin
                @(negedge Clk);
                obs = {CE, OE, WE, UB, LB, Data_oe, Busy, Done};
                e   = exp_sig(k, 2, wr, be);
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL access_strobes n=%0d cyc=%0d wr=%b be=%b got=%b exp=%b",
                             n, k, wr, be, obs, e);
                end
                checks++;
                if (ADDR !== {4'h0, a}) begin
                    failures++;
                    $display("FAIL access_addr n=%0d cyc=%0d got=%h exp=%h", n, k, ADDR, {4'h0, a});
                end
                if (wr && k <= 4) begin
                    checks++;
                    if (Data_out !== wd) begin
                        failures++;
                        $display("FAIL access_wdata n=%0d cyc=%0d got=%h exp=%h", n, k, Data_out, wd);
                    end
                end
                if (k == 4) begin
                    if (!wr) rd_exp = masked(din, be);
                    checks++;
                    if (RData !== rd_exp) begin
                        failures++;
                        $display("FAIL access_rdata n=%0d wr=%b be=%b got=%h exp=%h",
                                 n, wr, be, RData, rd_exp);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1, a2, wd2, din;
        logic [1:0]  be2;
        logic [7:0]  obs, e;
        int          kk;
        a1 = 16'($urandom); a2 = 16'($urandom); wd2 = 16'($urandom); din = 16'($urandom);
        be2 = 2'($urandom_range(1, 3));
        start_req(1'b0, 2'b11, a1, 16'h0, din, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            kk  = (k <= 4) ? k : k - 4;
            obs = {CE, OE, WE, UB, LB, Data_oe, Busy, Done};
            e   = (k <= 4) ? exp_sig(kk, 2, 1'b0, 2'b11) : exp_sig(kk, 2, 1'b1, be2);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL b2b_strobes cyc=%0d got=%b exp=%b", k, obs, e);
            end
            checks++;
            if (ADDR !== {4'h0, (k <= 4) ? a1 : a2}) begin
                failures++;
                $display("FAIL b2b_addr cyc=%0d got=%h exp=%h", k, ADDR, {4'h0, (k <= 4) ? a1 : a2});
            end
            if (k == 4 || k == 8) begin
                if (k == 4) rd_exp = din;
                checks++;
                if (RData !== rd_exp) begin
                    failures++;
                    $display("FAIL b2b_rdata cyc=%0d got=%h exp=%h", k, RData, rd_exp);
                end
            end
            if (k == 1) begin
                Write = 1'b1; Addr = a2; WData = wd2; ByteEn = be2;
            end
            if (k == 5) Req = 1'b0;
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] obs, e;
        start_req(1'b0, 2'b11, 16'h1111, 16'h0, 16'h7E81, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            obs = {CE, OE, WE, UB, LB, Data_oe, Busy, Done};
            e   = exp_sig(k, 2, 1'b0, 2'b11);
            checks++;
            if (obs !== e || ADDR !== 20'h01111) begin
                failures++;
                $display("FAIL busy_ignore cyc=%0d strobes=%b exp=%b ADDR=%h exp=01111",
                         k, obs, e, ADDR);
            end
            if (k == 2) begin
                Req = 1'b1; Write = 1'b1; Addr = 16'h2222; WData = 16'hDEAD;
            end
            if (k == 3) Req = 1'b0;
        end
        rd_exp = 16'h7E81;
        checks++;
        if (RData !== rd_exp) begin
            failures++;
            $display("FAIL busy_ignore_rdata got=%h exp=%h", RData, rd_exp);
        end
    endtask

    task automatic test_reset_mid_access();
        start_req(1'b1, 2'b11, 16'h0040, 16'hCAFE, 16'h0, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (WE !== 1'b0 || CE !== 1'b0 || Data_oe !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre WE=%b CE=%b Data_oe=%b exp 0 0 1", WE, CE, Data_oe);
        end
        Reset = 1'b1;
        #1;
        rd_exp = 16'h0000;
        s_rd_exp = 16'h0000;
        checks++;
        if ({CE, OE, WE, UB, LB, Data_oe, Busy, Done} !== 8'b11111000 ||
            ADDR !== 20'h0 || RData !== rd_exp) begin
            failures++;
            $display("FAIL reset_mid_async strobes=%b ADDR=%h RData=%h exp 11111000/0/0",
                     {CE, OE, WE, UB, LB, Data_oe, Busy, Done}, ADDR, RData);
        end
        #1 Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            checks++;
            if (Done !== 1'b0 || CE !== 1'b1 || Busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_after cyc=%0d Done=%b CE=%b Busy=%b exp 0 1 0",
                         k, Done, CE, Busy);
            end
        end
    endtask

    task automatic test_short_wait();
        logic [7:0]  obs, e;
        logic [1:0]  be;
        logic [15:0] din, a;
        for (int n = 0; n < 6; n++) begin
            be  = (n == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            din = 16'($urandom);
            a   = 16'($urandom);
            @(posedge Clk);
            #1;
            s_req = 1'b1; s_write = n[0]; s_byte_en = be; s_addr = a; s_wdata = din;
            s_data_in = din;
            @(posedge Clk);
            #1 s_req = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                @(negedge Clk);
                obs = {s_ce, s_oe, s_we, s_ub, s_lb, s_data_oe, s_busy, s_done};
                e   = exp_sig(k, 1, n[0], be);
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL wc1_strobes n=%0d cyc=%0d got=%b exp=%b", n, k, obs, e);
                end
                if (k == 3) begin
                    if (!n[0]) s_rd_exp = masked(din, be);
                    checks++;
                    if (s_rdata !== s_rd_exp || s_sram_addr !== {4'h0, a}) begin
                        failures++;
                        $display("FAIL wc1_rdata n=%0d RData=%h exp=%h ADDR=%h exp=%h",
                                 n, s_rdata, s_rd_exp, s_sram_addr, {4'h0, a});
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_access();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_access();
        test_short_wait();
        @(negedge Clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
